// File: rtl/fan_pkg.sv
// Shared types and helpers for the fan drive path:
// state encoding and the speed-level to duty mapping.
package fan_pkg;

    localparam int FAN_MODE_W = 3;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        KICK  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } fan_state_t;

    // Top level maps to full duty so the fan can reach 100%.
    function automatic int unsigned mode_to_duty(
        input logic [FAN_MODE_W-1:0] mode,
        input int unsigned           pwm_bits
    );
        if (mode == '1) begin
            return 32'd1 << pwm_bits;
        end
        return 32'(mode) << (pwm_bits - 32'd3);
    endfunction

endpackage

// File: rtl/fan_pwm_driver_tach_edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
// Shared by the tach input and future sensor inputs.
module tach_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic [2:0] sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[1:0], async_in};
            pulse <= sync[1] & ~sync[2];
        end
    end

endmodule

// File: rtl/fan_pwm_driver.sv
// Fan PWM driver: slew-limited duty, spin-up kick and
// tach-based stall detection with a latched fault.
module fan_pwm_driver
    import fan_pkg::*;
#(
    parameter int PWM_BITS      = 4,
    parameter int KICK_PERIODS  = 4,
    parameter int STALL_PERIODS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FAN_MODE_W-1:0] fan_mode,
    input  logic                  fan_tach,
    input  logic                  fault_clr,
    output logic                  pwm_out,
    output logic [PWM_BITS:0]     duty,
    output logic                  fan_running,
    output logic                  fan_fault,
    output logic [1:0]            fan_state
);

    localparam int KW = $clog2(KICK_PERIODS + 1);
    localparam int SW = $clog2(STALL_PERIODS + 1);

    localparam logic [PWM_BITS:0] FULL      = (PWM_BITS+1)'(1 << PWM_BITS);
    localparam logic [PWM_BITS:0] DUTY_ONE  = (PWM_BITS+1)'(1);
    localparam logic [KW-1:0]     KICK_LAST = KW'(KICK_PERIODS - 1);
    localparam logic [SW-1:0]     STALL_MAX = SW'(STALL_PERIODS);

    fan_state_t            state;
    fan_state_t            state_nxt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [PWM_BITS:0]     duty_nxt;
    logic [PWM_BITS:0]     target;
    logic [KW-1:0]         kick_cnt;
    logic [KW-1:0]         kick_nxt;
    logic [SW-1:0]         stall_cnt;
    logic [SW-1:0]         stall_nxt;
    logic                  period_end;
    logic                  tach_edge;
    logic                  fault_entry;

    tach_edge_sync u_tach (
        .clk      (clk),
        .rst      (rst),
        .async_in (fan_tach),
        .pulse    (tach_edge)
    );

    assign period_end = (pwm_cnt == '1);
    assign target     = (PWM_BITS+1)'(mode_to_duty(fan_mode, PWM_BITS));
    assign fault_entry = (state == RUN) && (state_nxt == FAULT);
    assign fan_state  = state;

    always_comb begin
        state_nxt = state;
        duty_nxt  = duty;
        kick_nxt  = kick_cnt;
        stall_nxt = '0;
        unique case (state)
            OFF: begin
                duty_nxt = '0;
                kick_nxt = '0;
                if (period_end && target != '0) begin
                    state_nxt = KICK;
                    duty_nxt  = FULL;
                end
            end
            KICK: begin
                duty_nxt = FULL;
                if (period_end) begin
                    if (target == '0) begin
                        state_nxt = OFF;
                        duty_nxt  = '0;
                    end else if (kick_cnt == KICK_LAST) begin
                        state_nxt = RUN;
                    end else begin
                        kick_nxt = kick_cnt + KW'(1);
                    end
                end
            end
            RUN: begin
                kick_nxt = '0;
                // A tach edge beats a coincident period increment.
                if (tach_edge || duty == '0) begin
                    stall_nxt = '0;
                end else if (period_end && stall_cnt != STALL_MAX) begin
                    stall_nxt = stall_cnt + SW'(1);
                end else begin
                    stall_nxt = stall_cnt;
                end
                if (stall_nxt == STALL_MAX) begin
                    state_nxt = FAULT;
                    duty_nxt  = '0;
                    stall_nxt = '0;
                end else if (period_end) begin
                    if (duty == '0 && target == '0) begin
                        state_nxt = OFF;
                    end else if (duty < target) begin
                        duty_nxt = duty + DUTY_ONE;
                    end else if (duty > target) begin
                        duty_nxt = duty - DUTY_ONE;
                    end
                end
            end
            FAULT: begin
                duty_nxt = '0;
                kick_nxt = '0;
                if (fault_clr) begin
                    state_nxt = OFF;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= OFF;
            pwm_cnt     <= '0;
            duty        <= '0;
            kick_cnt    <= '0;
            stall_cnt   <= '0;
            pwm_out     <= 1'b0;
            fan_running <= 1'b0;
            fan_fault   <= 1'b0;
        end else begin
            state       <= state_nxt;
            pwm_cnt     <= pwm_cnt + PWM_BITS'(1);
            duty        <= duty_nxt;
            kick_cnt    <= kick_nxt;
            stall_cnt   <= stall_nxt;
            pwm_out     <= !fault_entry && ({1'b0, pwm_cnt} < duty);
            fan_running <= (state_nxt == KICK) || (state_nxt == RUN);
            fan_fault   <= (state_nxt == FAULT);
        end
    end

endmodule
